// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
//   mem_state_t        : access FSM states
//   FAULT_DATA_DEFAULT : load result returned on an aborted or faulted load
//   be_for()           : byte enables for a given address low bits / access size
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [DATA_W-1:0] FAULT_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // One-hot lane for byte accesses, all lanes for word accesses.
    function automatic logic [BE_W-1:0] be_for(input logic [1:0] addr_lo, input logic byte_acc);
        return byte_acc ? (BE_W'(1) << addr_lo) : {BE_W{1'b1}};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and the 32-bit data-memory bus.
//   st_lo_i/st_byte_i/st_wdata_i : store side address bits, size, raw data
//   st_be_o/st_wdata_o           : byte enables and lane-replicated store data
//   ld_lo_i/ld_byte_i/ld_rdata_i : load side address bits, size, bus data
//   ld_data_o                    : zero-extended load result
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]        st_lo_i,
    input  logic              st_byte_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    output logic [BE_W-1:0]   st_be_o,
    output logic [DATA_W-1:0] st_wdata_o,
    input  logic [1:0]        ld_lo_i,
    input  logic              ld_byte_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0] ld_byte_sel;

    // Store side: byte stores drive the same byte on every lane.
    always_comb begin
        st_be_o    = be_for(st_lo_i, st_byte_i);
        st_wdata_o = st_byte_i ? {4{st_wdata_i[7:0]}} : st_wdata_i;
    end

    // Load side: pick the addressed lane and zero-extend.
    always_comb begin
        ld_byte_sel = ld_rdata_i[7:0];
        case (ld_lo_i)
            2'd0: ld_byte_sel = ld_rdata_i[7:0];
            2'd1: ld_byte_sel = ld_rdata_i[15:8];
            2'd2: ld_byte_sel = ld_rdata_i[23:16];
            2'd3: ld_byte_sel = ld_rdata_i[31:24];
            default: ld_byte_sel = ld_rdata_i[7:0];
        endcase
        ld_data_o = ld_byte_i ? {24'h0, ld_byte_sel} : ld_rdata_i;
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: turns a flagged load/store into one req/ack
// bus transaction, stalls the pipeline until ack or timeout, and presents
// aligned load data for one DONE cycle.
//   clk, reset (async, active-low)
//   MemReadM/MemWriteM/ByteM/ALUOutM/WriteDataM : access from EX/MEM
//   ReadDataM/StallM/MemFaultM                   : to pipeline (decoded)
//   dmem_req/we/addr/be/wdata                    : registered bus request
//   dmem_ack/dmem_rdata                          : bus response
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned       TIMEOUT    = 16,
    parameter logic [DATA_W-1:0] FAULT_DATA = FAULT_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              ByteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MemFaultM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        lo_q, lo_d;
    logic              byte_q, byte_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              access_c;
    logic              misaligned_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ld_data_c;

    assign access_c     = MemReadM | MemWriteM;
    assign misaligned_c = !ByteM && (ALUOutM[1:0] != 2'b00);

    // Issue side uses live inputs; capture side uses the registered lane.
    mem_lane_align u_lane (
        .st_lo_i    (ALUOutM[1:0]),
        .st_byte_i  (ByteM),
        .st_wdata_i (WriteDataM),
        .st_be_o    (be_c),
        .st_wdata_o (wdata_c),
        .ld_lo_i    (lo_q),
        .ld_byte_i  (byte_q),
        .ld_rdata_i (dmem_rdata),
        .ld_data_o  (ld_data_c)
    );

    // State and bus request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            byte_q  <= 1'b0;
            data_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; bus fields hold while BUSY.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        byte_d  = byte_q;
        data_d  = data_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    if (misaligned_c) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        data_d  = MemWriteM ? '0 : FAULT_DATA;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        lo_d    = ALUOutM[1:0];
                        byte_d  = ByteM;
                        fault_d = 1'b0;
                        data_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    data_d  = we_q ? '0 : ld_data_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    data_d  = we_q ? '0 : FAULT_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                fault_d = 1'b0;
                data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline-facing decode; forced low while reset is asserted.
    always_comb begin
        StallM    = reset && (((state_q == IDLE) && access_c) || (state_q == BUSY));
        MemFaultM = reset && (state_q == DONE) && fault_q;
        ReadDataM = (state_q == DONE) ? data_q : '0;
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard-based bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MemFaultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          stall;
        int          reqc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemFaultM  (MemFaultM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Drive one access, respond on the bus after ack_dly BUSY cycles (-1: never),
    // then compare the DONE cycle against the queued expectation.
    task automatic access(input logic rd, input logic wr, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_dly, input string name);
        exp_t e;
        logic mis, tmo;
        logic [7:0] lane;
        int stall, busy;
        bit done;
        mis  = !byt && (addr[1:0] != 2'b00);
        tmo  = !mis && (ack_dly < 0 || ack_dly >= int'(T));
        lane = rdata[8*addr[1:0] +: 8];
        e.we    = wr;
        e.addr  = {addr[31:2], 2'b00};
        e.be    = byt ? (4'b0001 << addr[1:0]) : 4'hF;
        e.wdata = byt ? {4{wdata[7:0]}} : wdata;
        e.fault = mis || tmo;
        e.reqc  = mis ? 0 : (tmo ? int'(T) : ack_dly + 1);
        e.stall = 1 + e.reqc;
        if (wr)             e.data = 32'h0;
        else if (mis || tmo) e.data = 32'hDEAD_BEEF;
        else if (byt)        e.data = {24'h0, lane};
        else                 e.data = rdata;
        sb.push_back(e);

        stall = 0;
        busy  = 0;
        done  = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                MemReadM   = rd;
                MemWriteM  = wr;
                ByteM      = byt;
                ALUOutM    = addr;
                WriteDataM = wdata;
            end
            dmem_rdata = rdata;
            dmem_ack   = dmem_req && (busy == ack_dly);
            #1;
            if (StallM) begin
                stall++;
                if (dmem_req) begin
                    n_checks++;
                    if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata}) begin
                        n_fail++;
                        $display("FAIL %s bus: we/addr/be/wdata got %b/%h/%h/%h want %b/%h/%h/%h",
                                 name, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                                 sb[0].we, sb[0].addr, sb[0].be, sb[0].wdata);
                    end
                    busy++;
                end
            end else begin
                done = 1;
                e = sb.pop_front();
                n_checks++;
                if (ReadDataM !== e.data) begin
                    n_fail++;
                    $display("FAIL %s ReadDataM: got %h want %h", name, ReadDataM, e.data);
                end
                n_checks++;
                if (MemFaultM !== e.fault) begin
                    n_fail++;
                    $display("FAIL %s MemFaultM: got %b want %b", name, MemFaultM, e.fault);
                end
                n_checks++;
                if (stall != e.stall || busy != e.reqc) begin
                    n_fail++;
                    $display("FAIL %s latency: stall %0d req %0d want stall %0d req %0d",
                             name, stall, busy, e.stall, e.reqc);
                end
                n_checks++;
                if (dmem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s req_in_done: got %b want 0", name, dmem_req);
                end
            end
        end
        dmem_ack = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s no_done: stall never released within 40 cycles, want DONE", name);
            void'(sb.pop_front());
        end
    endtask

    // One cycle with no access: the unit must be quiet.
    task automatic idle_check(input string name, input logic stray_ack);
        @(negedge clk);
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        dmem_ack   = stray_ack;
        dmem_rdata = 32'h5555_AAAA;
        #1;
        n_checks++;
        if ({StallM, MemFaultM, dmem_req, ReadDataM} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL %s idle: stall/fault/req/rdata got %b/%b/%b/%h want 0/0/0/0",
                     name, StallM, MemFaultM, dmem_req, ReadDataM);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        MemReadM = 0; MemWriteM = 0; ByteM = 0;
        ALUOutM = '0; WriteDataM = '0; dmem_ack = 0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({ReadDataM, StallM, MemFaultM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero, req=%b addr=%h be=%h stall=%b",
                     dmem_req, dmem_addr, dmem_be, StallM);
        end
        @(negedge clk);
        reset = 1'b1;
        idle_check("post_reset", 1'b0);
    endtask

    task automatic test_word_load();
        access(1, 0, 0, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, "word_load");
        idle_check("word_load", 1'b0);
    endtask

    task automatic test_byte_store();
        access(0, 1, 1, 32'h0000_0203, 32'h1234_56AB, 32'hFFFF_FFFF, 3, "byte_store");
        idle_check("byte_store", 1'b0);
    endtask

    task automatic test_byte_load();
        access(1, 0, 1, 32'h0000_0302, 32'h0, 32'h11C3_2233, 1, "byte_load");
        idle_check("byte_load", 1'b0);
    endtask

    task automatic test_timeout();
        access(1, 0, 0, 32'h0000_0400, 32'h0, 32'h7777_7777, -1, "timeout_load");
        idle_check("stray_ack", 1'b1);
        idle_check("after_stray", 1'b0);
        access(0, 1, 0, 32'h0000_0404, 32'h0102_0304, 32'h0, -1, "timeout_store");
        idle_check("timeout_store", 1'b0);
    endtask

    task automatic test_misaligned();
        access(1, 0, 0, 32'h0000_0102, 32'h0, 32'h2222_2222, 0, "misaligned_load");
        idle_check("misaligned_load", 1'b0);
        access(0, 1, 0, 32'h0000_0106, 32'h3333_3333, 32'h0, 0, "misaligned_store");
        idle_check("misaligned_store", 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        MemReadM = 1; MemWriteM = 0; ByteM = 0;
        ALUOutM = 32'h0000_0080; WriteDataM = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ReadDataM, StallM, MemFaultM, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: outputs not all zero, req=%b addr=%h be=%h wdata=%h stall=%b",
                     dmem_req, dmem_addr, dmem_be, dmem_wdata, StallM);
        end
        @(negedge clk);
        MemReadM = 0;
        dmem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1'b0;
        idle_check("after_reset_release", 1'b0);
        access(1, 0, 0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 1, "load_after_reset");
        idle_check("load_after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        access(0, 1, 0, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 1, "b2b_store");
        access(1, 0, 0, 32'h0000_0504, 32'h0, 32'h0BAD_F00D, 2, "b2b_load");
        access(1, 0, 1, 32'h0000_0501, 32'h0, 32'h00AA_5500, 0, "b2b_byte_lane1");
        access(1, 1, 1, 32'h0000_0500, 32'h0000_0099, 32'hFFFF_FFFF, 0, "rd_wr_as_store");
        access(1, 0, 0, 32'h0000_0508, 32'h0, 32'h0F0F_0F0F, 3, "b2b_last_cycle_ack");
        idle_check("back_to_back", 1'b0);
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_timeout();
        test_misaligned();
        test_reset_mid_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
